player_controller: RTL

PLAYER_CONTROLLER -- requirements
Module: player_controller

---
 rtl/player_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/player_controller.sv
// rtl/player_controller.sv - player sprite position, facing and attack FSM
// Frame ticks come from a synchronised frame_clk rising edge; all game state advances once per tick.
module player_controller #(
  parameter logic [9:0]  X_START    = 10'd304,
  parameter logic [9:0]  Y_START    = 10'd224,
  parameter logic [9:0]  X_MAX      = 10'd608,
  parameter logic [9:0]  Y_MAX      = 10'd448,
  parameter logic [9:0]  STEP       = 10'd2,
  parameter int unsigned ATK_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] Player_X,
  output logic [9:0] Player_Y,
  output logic [1:0] facing,
  output logic       attacking
);
  localparam int CW = $clog2(ATK_FRAMES + 1);
  localparam logic [7:0] KEY_UP = 8'h1A, KEY_DOWN = 8'h16, KEY_LEFT = 8'h04,
                         KEY_RIGHT = 8'h07, KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {IDLE, WALK, ATTACK} state_t;

  logic          sync1_q, sync2_q, sync3_q, vld_q, primed_q;
  logic          sync1_d, sync2_d, sync3_d, vld_d, primed_d;
  logic [9:0]    x_q, y_q, x_d, y_d;
  logic [1:0]    facing_q, facing_d;
  state_t        state_q, state_d;
  logic [CW-1:0] atk_cnt_q, atk_cnt_d;
  logic          armed_q, armed_d, attacking_q, attacking_d;

  logic          frame_tick, is_move, do_move;
  logic [1:0]    dir;
  logic [10:0]   x_w, y_w, step_w;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    vld_d   = 1'b1;
    // A level that was already high when reset released must go low before it can count as an edge.
    primed_d   = primed_q | (vld_q & ~sync1_q);
    frame_tick = sync2_q & ~sync3_q & primed_q;

    is_move = 1'b1;
    dir     = facing_q;
    case (keycode)
      KEY_UP:    dir = 2'b00;
      KEY_DOWN:  dir = 2'b01;
      KEY_LEFT:  dir = 2'b10;
      KEY_RIGHT: dir = 2'b11;
      default:   is_move = 1'b0;
    endcase

    x_d         = x_q;
    y_d         = y_q;
    facing_d    = facing_q;
    state_d     = state_q;
    atk_cnt_d   = atk_cnt_q;
    armed_d     = armed_q;
    do_move     = 1'b0;

    if (frame_tick) begin
      if (keycode != KEY_SPACE) armed_d = 1'b1;
      if (state_q == ATTACK) begin
        if (atk_cnt_q != '0) begin
          atk_cnt_d = atk_cnt_q - 1'b1;
        end else begin
          do_move = is_move;
          state_d = is_move ? WALK : IDLE;
        end
      end else if (keycode == KEY_SPACE && armed_q) begin
        state_d   = ATTACK;
        atk_cnt_d = CW'(ATK_FRAMES - 1);
        armed_d   = 1'b0;
      end else begin
        do_move = is_move;
        state_d = is_move ? WALK : IDLE;
      end
    end

    x_w    = {1'b0, x_q};
    y_w    = {1'b0, y_q};
    step_w = {1'b0, STEP};
    if (do_move) begin
      facing_d = dir;
      case (dir)
        2'b00:   y_d = (y_w < step_w) ? 10'd0 : 10'(y_w - step_w);
        2'b01:   y_d = (y_w + step_w > {1'b0, Y_MAX}) ? Y_MAX : 10'(y_w + step_w);
        2'b10:   x_d = (x_w < step_w) ? 10'd0 : 10'(x_w - step_w);
        default: x_d = (x_w + step_w > {1'b0, X_MAX}) ? X_MAX : 10'(x_w + step_w);
      endcase
    end

    attacking_d = (state_d == ATTACK);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      vld_q       <= 1'b0;
      primed_q    <= 1'b0;
      x_q         <= X_START;
      y_q         <= Y_START;
      facing_q    <= 2'b01;
      state_q     <= IDLE;
      atk_cnt_q   <= '0;
      armed_q     <= 1'b1;
      attacking_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      vld_q       <= vld_d;
      primed_q    <= primed_d;
      x_q         <= x_d;
      y_q         <= y_d;
      facing_q    <= facing_d;
      state_q     <= state_d;
      atk_cnt_q   <= atk_cnt_d;
      armed_q     <= armed_d;
      attacking_q <= attacking_d;
    end
  end

  assign Player_X  = x_q;
  assign Player_Y  = y_q;
  assign facing    = facing_q;
  assign attacking = attacking_q;
endmodule
